// File: rtl/pix_out_packer.sv
// pix_out_packer
//   Output-side repacker on clk_out_int. Stage 1 converts every component of
//   the 4-pixel input word from the coded depth (bits_per_component) to
//   OUT_BPC with clip, round and saturate. Stage 2 merges valid pixels with a
//   0..3 pixel residual into dense 4-pixel words, flushes the residual at end
//   of line / end of frame, and regenerates sof/eol/eof aligned to the data.
//   Optional feature macro: PIX_OUT_PACKER_LINE_CHECK_EN enables the per-line
//   pixel counter and line_len_err. Without it line_len_err is tied to 0.
// Ports
//   clk_out_int, rst_n (async, active-low), flush (sync clear of all state)
//   bits_per_component[3:0], frame_width[15:0]  : static configuration
//   in_sof, in_pixs[167:0], in_valid[3:0], in_eol, in_eof : input stream
//   out_sof, out_pixs[12*OUT_BPC-1:0], out_valid[3:0], out_eol, out_eof
//   mask_err, line_len_err : sticky status, cleared by in_sof
module pix_out_packer #(
  parameter int OUT_BPC         = 10,
  parameter int MAX_FRAME_WIDTH = 5120
) (
  input  logic                   clk_out_int,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [3:0]             bits_per_component,
  input  logic [15:0]            frame_width,
  input  logic                   in_sof,
  input  logic [167:0]           in_pixs,
  input  logic [3:0]             in_valid,
  input  logic                   in_eol,
  input  logic                   in_eof,
  output logic                   out_sof,
  output logic [12*OUT_BPC-1:0]  out_pixs,
  output logic [3:0]             out_valid,
  output logic                   out_eol,
  output logic                   out_eof,
  output logic                   mask_err,
  output logic                   line_len_err
);
  localparam int          PW   = 3 * OUT_BPC;
  localparam int          WW   = 12 * OUT_BPC;
  localparam logic [3:0]  OB   = 4'(OUT_BPC);
  localparam logic [15:0] OMAX = 16'((1 << OUT_BPC) - 1);

  // Clip to the coded range, then round-half-up and saturate when reducing
  // depth, or left-justify with zero fill when expanding.
  function automatic logic [OUT_BPC-1:0] fmt_comp(input logic [13:0] x, input logic [3:0] s);
    logic [15:0] maxv, xc, sum, y;
    logic [3:0]  sh;
    maxv = (16'd1 << s) - 16'd1;
    xc   = ({2'b00, x} > maxv) ? maxv : {2'b00, x};
    y    = xc;
    sh   = 4'd0;
    sum  = 16'd0;
    if (s > OB) begin
      sh  = s - OB;
      sum = xc + (16'd1 << (sh - 4'd1));
      y   = sum >> sh;
      if (y > OMAX) y = OMAX;
    end else if (s < OB) begin
      sh = OB - s;
      y  = xc << sh;
    end
    return y[OUT_BPC-1:0];
  endfunction

  function automatic logic [2:0] popcnt(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  function automatic logic [3:0] mask_of(input logic [2:0] k);
    case (k)
      3'd0:    return 4'b0000;
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  // ---------------- stage 1: format ----------------
  logic [2:0]    n_in;
  logic          contig, eof_rise;
  logic [WW-1:0] fmt_w;
  logic [WW-1:0] s1_pix_q;
  logic [2:0]    s1_n_q;
  logic          s1_sof_q, s1_eol_q, s1_eofr_q, eof_prev_q, mask_err_q;

  // The eof rising edge acts as an end of line; valid beats are dropped while eof is high.
  assign eof_rise = in_eof & ~eof_prev_q;

  always_comb begin
    n_in   = in_eof ? 3'd0 : popcnt(in_valid);
    contig = (in_valid == 4'b0000) || (in_valid == 4'b0001) || (in_valid == 4'b0011) ||
             (in_valid == 4'b0111) || (in_valid == 4'b1111);
    fmt_w  = '0;
    for (int p = 0; p < 4; p++)
      for (int c = 0; c < 3; c++)
        fmt_w[(p*3+c)*OUT_BPC +: OUT_BPC] = fmt_comp(in_pixs[(p*3+c)*14 +: 14], bits_per_component);
  end

  always_ff @(posedge clk_out_int) s1_pix_q <= fmt_w;

  always_ff @(posedge clk_out_int or negedge rst_n) begin
    if (!rst_n) begin
      s1_n_q <= 3'd0; s1_sof_q <= 1'b0; s1_eol_q <= 1'b0; s1_eofr_q <= 1'b0;
      eof_prev_q <= 1'b0; mask_err_q <= 1'b0;
    end else if (flush) begin
      s1_n_q <= 3'd0; s1_sof_q <= 1'b0; s1_eol_q <= 1'b0; s1_eofr_q <= 1'b0;
      eof_prev_q <= 1'b0; mask_err_q <= 1'b0;
    end else begin
      s1_n_q     <= n_in;
      s1_sof_q   <= in_sof;
      s1_eol_q   <= in_eol;
      s1_eofr_q  <= eof_rise;
      eof_prev_q <= in_eof;
      if (in_sof)                  mask_err_q <= 1'b0;
      else if (!in_eof && !contig) mask_err_q <= 1'b1;
    end
  end

  assign mask_err = mask_err_q;

`ifdef PIX_OUT_PACKER_LINE_CHECK_EN
  localparam int            CW    = $clog2(MAX_FRAME_WIDTH + 1);
  localparam logic [CW:0]   MAXC  = (CW+1)'(MAX_FRAME_WIDTH);
  logic [CW-1:0] cnt_q, sat_sum;
  logic [CW:0]   sum;
  logic          line_end, line_err_q;

  // An eof edge only closes a line that actually received pixels.
  always_comb begin
    sum      = {1'b0, cnt_q} + (CW+1)'(n_in);
    sat_sum  = (sum > MAXC) ? MAXC[CW-1:0] : sum[CW-1:0];
    line_end = in_eol | (eof_rise & (cnt_q != '0));
  end

  always_ff @(posedge clk_out_int or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0; line_err_q <= 1'b0;
    end else if (flush || in_sof) begin
      cnt_q <= '0; line_err_q <= 1'b0;
    end else if (line_end) begin
      cnt_q <= '0;
      if (16'(sat_sum) != frame_width) line_err_q <= 1'b1;
    end else begin
      cnt_q <= sat_sum;
    end
  end

  assign line_len_err = line_err_q;
`else
  localparam int unused_max_fw = MAX_FRAME_WIDTH;
  logic unused_fw;
  assign unused_fw    = ^frame_width;
  assign line_len_err = 1'b0;
`endif

  // ---------------- stage 2: pack ----------------
  logic [PW-1:0] inc [4];
  logic [PW-1:0] cmb [7];
  logic [PW-1:0] res_q [3];
  logic [PW-1:0] res_d [3];
  logic [2:0]    t, rem;
  logic          full, line_eol;
  logic [1:0]    r_q, r_d;
  logic          pend_q, pend_d, eofp_q, eofp_d;
  logic          out_sof_q, out_sof_d, out_eol_q, out_eol_d, out_eof_q, out_eof_d;
  logic [3:0]    out_valid_q, out_valid_d;
  logic [WW-1:0] out_pixs_q, out_pixs_d;

  // Combined sequence: residual pixels first, then the incoming beat.
  always_comb begin
    for (int i = 0; i < 4; i++) inc[i] = s1_pix_q[i*PW +: PW];
    for (int i = 0; i < 7; i++) cmb[i] = '0;
    case (r_q)
      2'd0: for (int j = 0; j < 4; j++) cmb[j] = inc[j];
      2'd1: begin
        cmb[0] = res_q[0];
        for (int j = 0; j < 4; j++) cmb[j+1] = inc[j];
      end
      2'd2: begin
        cmb[0] = res_q[0]; cmb[1] = res_q[1];
        for (int j = 0; j < 4; j++) cmb[j+2] = inc[j];
      end
      default: begin
        cmb[0] = res_q[0]; cmb[1] = res_q[1]; cmb[2] = res_q[2];
        for (int j = 0; j < 4; j++) cmb[j+3] = inc[j];
      end
    endcase
    t        = {1'b0, r_q} + s1_n_q;
    full     = t[2];
    rem      = {1'b0, t[1:0]};
    line_eol = s1_eol_q | s1_eofr_q;
  end

  always_comb begin
    for (int i = 0; i < 3; i++) res_d[i] = res_q[i];
    r_d         = r_q;
    pend_d      = 1'b0;
    eofp_d      = 1'b0;
    out_sof_d   = 1'b0;
    out_eol_d   = 1'b0;
    out_eof_d   = eofp_q;
    out_valid_d = 4'b0000;
    out_pixs_d  = out_pixs_q;
    if (s1_sof_q) begin
      // sof wins over any simultaneous eol and drops the residual.
      out_sof_d = 1'b1;
      r_d       = 2'd0;
    end else if (pend_q) begin
      // Second half of a full-word-plus-partial end of line.
      out_pixs_d  = {{PW{1'b0}}, res_q[2], res_q[1], res_q[0]};
      out_valid_d = mask_of({1'b0, r_q});
      out_eol_d   = 1'b1;
      r_d         = 2'd0;
    end else begin
      for (int i = 0; i < 3; i++) res_d[i] = full ? cmb[i+4] : cmb[i];
      if (full) begin
        out_pixs_d  = {cmb[3], cmb[2], cmb[1], cmb[0]};
        out_valid_d = 4'b1111;
      end
      if (line_eol) begin
        r_d = 2'd0;
        if (rem != 3'd0) begin
          if (full) begin
            pend_d = 1'b1;
            r_d    = rem[1:0];
          end else begin
            out_pixs_d  = {cmb[3], cmb[2], cmb[1], cmb[0]};
            out_valid_d = mask_of(rem);
            out_eol_d   = 1'b1;
          end
        end else if (full || s1_eol_q) begin
          out_eol_d = 1'b1;
        end
        if (s1_eofr_q) begin
          if (rem != 3'd0 || full) eofp_d = 1'b1;
          else                     out_eof_d = 1'b1;
        end
      end else begin
        r_d = rem[1:0];
      end
    end
  end

  always_ff @(posedge clk_out_int) begin
    for (int i = 0; i < 3; i++) res_q[i] <= res_d[i];
  end

  always_ff @(posedge clk_out_int or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 2'd0; pend_q <= 1'b0; eofp_q <= 1'b0;
      out_sof_q <= 1'b0; out_eol_q <= 1'b0; out_eof_q <= 1'b0;
      out_valid_q <= 4'b0000; out_pixs_q <= '0;
    end else if (flush) begin
      r_q <= 2'd0; pend_q <= 1'b0; eofp_q <= 1'b0;
      out_sof_q <= 1'b0; out_eol_q <= 1'b0; out_eof_q <= 1'b0;
      out_valid_q <= 4'b0000; out_pixs_q <= '0;
    end else begin
      r_q <= r_d; pend_q <= pend_d; eofp_q <= eofp_d;
      out_sof_q <= out_sof_d; out_eol_q <= out_eol_d; out_eof_q <= out_eof_d;
      out_valid_q <= out_valid_d; out_pixs_q <= out_pixs_d;
    end
  end

  assign out_sof   = out_sof_q;
  assign out_pixs  = out_pixs_q;
  assign out_valid = out_valid_q;
  assign out_eol   = out_eol_q;
  assign out_eof   = out_eof_q;
endmodule
